// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. Decodes the opcode held
//   in the instruction register and sequences every datapath control line.
//   The machine is Moore: all control outputs decode from the state register.
//   In IMM_EXEC, ExtSel and ALUOp also look at Op, which is stable there
//   because the IR only loads in FETCH.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high; state -> FETCH, RetireCount -> 0
//   Op           opcode, Instruction[31:26]
//   PCWriteCond  PC write if ALU Zero
//   PCWrite      unconditional PC write
//   IorD         memory address select (0 = PC, 1 = ALUOut)
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   MemtoReg     register write data (0 = ALUOut, 1 = MDR)
//   IRWrite      instruction register load
//   RegDst       destination register (0 = rt, 1 = rd)
//   RegWrite     register-file write
//   ALUSrcA      ALU A input (0 = PC, 1 = A)
//   ALUSrcB      ALU B input (00 B, 01 4, 10 ext imm, 11 sext imm << 2)
//   ExtSel       immediate extension (0 = sign, 1 = zero)
//   ALUOp        00 add, 01 sub, 10 funct, 11 or
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   IllegalOp    high while in ILLEGAL
//   State        current state encoding
//   RetireCount  completed-instruction count, wraps modulo 2^CNT_W
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    output logic             PCWriteCond,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtSel,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             IllegalOp,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] RetireCount
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        IMM_EXEC  = 4'd10,
        IMM_WB    = 4'd11,
        ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_t           state;
    state_t           next_state;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            retire_cnt <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                case (Op)
                    OP_RTYPE:        next_state = R_EXEC;
                    OP_LW, OP_SW:    next_state = MEM_ADDR;
                    OP_BEQ:          next_state = BRANCH;
                    OP_J:            next_state = JUMP;
                    OP_ADDI, OP_ORI: next_state = IMM_EXEC;
                    default:         next_state = ILLEGAL;
                endcase
            end
            MEM_ADDR: next_state = (Op == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: next_state = MEM_WB;
            R_EXEC:   next_state = R_WB;
            IMM_EXEC: next_state = IMM_WB;
            default:  next_state = FETCH;
        endcase
    end

    // Every completing state returns to FETCH; ILLEGAL and unused codes do not count.
    always_comb begin
        retire = 1'b0;
        case (state)
            MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, IMM_WB: retire = 1'b1;
            default:                                       retire = 1'b0;
        endcase
    end

    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ExtSel      = 1'b0;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_ORI) begin
                    ExtSel = 1'b1;
                    ALUOp  = 2'b11;
                end
            end
            IMM_WB: begin
                RegWrite = 1'b1;
            end
            ILLEGAL: begin
                IllegalOp = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign State       = state;
    assign RetireCount = retire_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: a 32-bit-counter instance and a 4-bit-counter
// instance share all inputs. Each instruction's expected state walk, per-state
// control word and retire count come from an instruction-level model.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  Op;

    logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic        RegDst, RegWrite, ALUSrcA, ExtSel, IllegalOp;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  State;
    logic [31:0] RetireCount;

    logic        s_PCWriteCond, s_PCWrite, s_IorD, s_MemRead, s_MemWrite, s_MemtoReg, s_IRWrite;
    logic        s_RegDst, s_RegWrite, s_ALUSrcA, s_ExtSel, s_IllegalOp;
    logic [1:0]  s_ALUSrcB, s_ALUOp, s_PCSource;
    logic [3:0]  s_State;
    logic [3:0]  s_RetireCount;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned model_cnt;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State),
        .RetireCount(RetireCount)
    );

    multicycle_control #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWriteCond(s_PCWriteCond), .PCWrite(s_PCWrite), .IorD(s_IorD), .MemRead(s_MemRead),
        .MemWrite(s_MemWrite), .MemtoReg(s_MemtoReg), .IRWrite(s_IRWrite), .RegDst(s_RegDst),
        .RegWrite(s_RegWrite), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ExtSel(s_ExtSel),
        .ALUOp(s_ALUOp), .PCSource(s_PCSource), .IllegalOp(s_IllegalOp), .State(s_State),
        .RetireCount(s_RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] ctrl_main();
        return {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSource, IllegalOp};
    endfunction

    function automatic logic [17:0] ctrl_small();
        return {s_PCWriteCond, s_PCWrite, s_IorD, s_MemRead, s_MemWrite, s_MemtoReg, s_IRWrite,
                s_RegDst, s_RegWrite, s_ALUSrcA, s_ALUSrcB, s_ExtSel, s_ALUOp, s_PCSource,
                s_IllegalOp};
    endfunction

    // Control word each step of an instruction should present, straight from the step table.
    function automatic logic [17:0] exp_ctrl(input int unsigned st, input logic [5:0] op);
        logic pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rwr, srca, ext, ill;
        logic [1:0] srcb, aop, pcs;
        {pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rwr, srca, ext, ill} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rwr = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rwr = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin
                srca = 1; srcb = 2'b10;
                if (op == 6'b001101) begin ext = 1; aop = 2'b11; end
            end
            11: rwr = 1;
            12: ill = 1;
            default: ;
        endcase
        return {pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rwr, srca, srcb, ext, aop, pcs, ill};
    endfunction

    // Instruction-level model: the sequence of steps an opcode walks through.
    function automatic void build_path(input logic [5:0] op, output int unsigned p[$],
                                       output bit retires);
        p = {0, 1};
        retires = 1'b1;
        case (op)
            6'b100011: p = {p, 2, 3, 4};
            6'b101011: p = {p, 2, 5};
            6'b000000: p = {p, 6, 7};
            6'b000100: p.push_back(8);
            6'b000010: p.push_back(9);
            6'b001000, 6'b001101: p = {p, 10, 11};
            default: begin p.push_back(12); retires = 1'b0; end
        endcase
    endfunction

    task automatic check_step(input string tag, input int unsigned st, input logic [5:0] op);
        check({tag, ".state"}, 64'(State), 64'(st));
        check({tag, ".ctrl"}, 64'(ctrl_main()), 64'(exp_ctrl(st, op)));
        check({tag, ".cnt"}, 64'(RetireCount), 64'(model_cnt));
        check({tag, ".s_state"}, 64'(s_State), 64'(st));
        check({tag, ".s_ctrl"}, 64'(ctrl_small()), 64'(exp_ctrl(st, op)));
        check({tag, ".s_cnt"}, 64'(s_RetireCount), 64'(model_cnt % 16));
    endtask

    // Called with the DUT presenting FETCH; returns with it presenting FETCH again.
    task automatic run_instr(input logic [5:0] op);
        int unsigned p[$];
        bit          ret;
        string       tag;
        Op = op;
        build_path(op, p, ret);
        tag = $sformatf("op%02h", op);
        foreach (p[i]) begin
            check_step(tag, p[i], op);
            @(posedge clk); #1;
        end
        if (ret) model_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_cnt = 0;
    endtask

    logic [5:0] legal_ops [7];
    logic [5:0] rop;

    initial begin
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b000010, 6'b001000, 6'b001101};
        vectors = 0;
        miscompares = 0;
        model_cnt = 0;
        Op = 6'b000000;
        do_reset();
        check_step("reset", 0, Op);

        // Directed walk through every instruction class, then an illegal opcode.
        run_instr(6'b100011);
        run_instr(6'b000000);
        run_instr(6'b101011);
        run_instr(6'b000100);
        run_instr(6'b000010);
        run_instr(6'b001101);
        run_instr(6'b001000);
        run_instr(6'b111111);
        check_step("after_illegal", 0, Op);

        // Randomized mix of legal and arbitrary opcodes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(1, 0) == 0) rop = legal_ops[$urandom_range(6, 0)];
            else                           rop = 6'($urandom);
            run_instr(rop);
        end

        // Reset in the middle of a store: FETCH, DECODE, MEM_ADDR, then MEM_WRITE.
        Op = 6'b101011;
        repeat (3) begin @(posedge clk); #1; end
        check("midsw.state", 64'(State), 64'd5);
        check("midsw.memwrite", 64'(MemWrite), 64'd1);
        do_reset();
        check_step("midsw_reset", 0, Op);
        check("midsw_reset.memwrite", 64'(MemWrite), 64'd0);

        // Sixteen retirements: the 4-bit counter wraps back to 0.
        for (int n = 0; n < 16; n++) run_instr(6'b000010);
        check("wrap.small", 64'(s_RetireCount), 64'd0);
        check("wrap.big", 64'(RetireCount), 64'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
